// File: rtl/dmem_arbiter.sv
// Arbitrates the single dmem port between the CPU core and a DMA burst engine.
// The core is served with zero added latency; granted DMA bursts run uninterrupted.
module dmem_arbiter #(
  parameter int BURST_MAX    = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int LEN_W        = $clog2(BURST_MAX) + 1,
  parameter int DMEM_DEPTH   = 16,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req_i,
  input  logic [3:0]            core_we_i,
  input  logic [DMEM_DEPTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  dma_req_i,
  input  logic                  dma_wr_i,
  input  logic [DMEM_DEPTH-1:0] dma_addr_i,
  input  logic [LEN_W-1:0]      dma_len_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  output logic                  dma_gnt_o,
  output logic                  dma_beat_o,
  output logic [DATA_WIDTH-1:0] dma_rdata_o,
  output logic                  dma_done_o,
  output logic [3:0]            mem_we_o,
  output logic [DMEM_DEPTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]  STARVE_MAX  = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);
  localparam logic [LEN_W-1:0] BURST_MAX_L = LEN_W'(BURST_MAX);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

  typedef enum logic {S_CORE, S_DMA} state_t;

  state_t                state_reg, state_next;
  logic [SC_W-1:0]       starve_cnt_reg, starve_cnt_next;
  logic [LEN_W-1:0]      beat_cnt_reg, beat_cnt_next;
  logic [LEN_W-1:0]      len_reg, len_next;
  logic [DMEM_DEPTH-1:0] base_reg, base_next;
  logic                  wr_reg, wr_next;

  logic [LEN_W-1:0]      len_eff;
  logic [DMEM_DEPTH-1:0] beat_off;
  logic                  starved;
  logic                  take_dma;
  logic                  last_beat;

  // Zero-length requests become one beat; oversize requests clamp to BURST_MAX.
  always_comb begin
    len_eff = dma_len_i;
    if (dma_len_i == '0) begin
      len_eff = LEN_ONE;
    end else if (dma_len_i > BURST_MAX_L) begin
      len_eff = BURST_MAX_L;
    end
  end

  assign beat_off  = DMEM_DEPTH'({beat_cnt_reg, 2'b00});
  assign starved   = (starve_cnt_reg == STARVE_MAX);
  assign last_beat = (beat_cnt_reg == (len_reg - LEN_ONE));
  // Gated with rst_n so no grant pulse escapes while reset is held.
  assign take_dma  = rst_n & (state_reg == S_CORE) & dma_req_i & (~core_req_i | starved);

  assign core_rdata_o = mem_rdata_i;
  assign dma_rdata_o  = mem_rdata_i;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    beat_cnt_next   = beat_cnt_reg;
    len_next        = len_reg;
    base_next       = base_reg;
    wr_next         = wr_reg;
    core_stall_o    = 1'b0;
    dma_gnt_o       = 1'b0;
    dma_beat_o      = 1'b0;
    dma_done_o      = 1'b0;
    mem_we_o        = core_we_i & {4{core_req_i}};
    mem_addr_o      = core_addr_i;
    mem_wdata_o     = core_wdata_i;

    case (state_reg)
      S_CORE: begin
        if (take_dma) begin
          // The core is still served on the grant cycle; beats start next cycle.
          dma_gnt_o       = 1'b1;
          base_next       = dma_addr_i;
          len_next        = len_eff;
          wr_next         = dma_wr_i;
          beat_cnt_next   = '0;
          starve_cnt_next = '0;
          state_next      = S_DMA;
        end else if (dma_req_i && core_req_i) begin
          if (!starved) begin
            starve_cnt_next = starve_cnt_reg + SC_ONE;
          end
        end else if (!dma_req_i) begin
          starve_cnt_next = '0;
        end
      end

      S_DMA: begin
        dma_beat_o    = 1'b1;
        core_stall_o  = core_req_i;
        mem_addr_o    = base_reg + beat_off;
        mem_we_o      = wr_reg ? 4'hF : 4'h0;
        mem_wdata_o   = dma_wdata_i;
        beat_cnt_next = beat_cnt_reg + LEN_ONE;
        if (last_beat) begin
          dma_done_o = 1'b1;
          state_next = S_CORE;
        end
      end

      default: state_next = S_CORE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_CORE;
      starve_cnt_reg <= '0;
      beat_cnt_reg   <= '0;
      len_reg        <= '0;
      base_reg       <= '0;
      wr_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      beat_cnt_reg   <= beat_cnt_next;
      len_reg        <= len_next;
      base_reg       <= base_next;
      wr_reg         <= wr_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected port events,
// a monitor pops and compares them whenever the DUT serves the core or the DMA.
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 5;

  logic          clk;
  logic          rst_n;
  logic          core_req;
  logic [3:0]    core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  logic          dma_req;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [LW-1:0] dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_beat;
  logic [DW-1:0] dma_rdata;
  logic          dma_done;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(
    .BURST_MAX(16), .STARVE_LIMIT(8), .LEN_W(LW), .DMEM_DEPTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .dma_req_i(dma_req), .dma_wr_i(dma_wr), .dma_addr_i(dma_addr), .dma_len_i(dma_len),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt), .dma_beat_o(dma_beat),
    .dma_rdata_o(dma_rdata), .dma_done_o(dma_done),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model: read and write on negedge, same-cycle read returns old data.
  logic [DW-1:0] mem [0:(1<<(AW-2))-1];
  always @(negedge clk) begin
    mem_rdata <= mem[mem_addr[AW-1:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) mem[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct packed {
    logic          gnt;
    logic          beat;
    logic          done;
    logic          stall;
    logic          chk_addr;
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   nev = 0;

  function automatic void expect_ev(input logic gnt, input logic beat, input logic done,
                                    input logic stall, input logic chk_addr,
                                    input logic [AW-1:0] addr, input logic [3:0] we,
                                    input logic chk_rd, input logic [DW-1:0] rdata);
    exp_t e;
    e.gnt = gnt; e.beat = beat; e.done = done; e.stall = stall;
    e.chk_addr = chk_addr; e.addr = addr; e.we = we; e.chk_rd = chk_rd; e.rdata = rdata;
    exp_q.push_back(e);
  endfunction

  // Monitor: an event is any cycle with a grant, a beat, or a served core access.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && (dma_gnt || dma_beat || (core_req && !core_stall))) begin
        nev++;
        nchk++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_event#%0d: got gnt=%b beat=%b done=%b addr=%h, required no event",
                   nev, dma_gnt, dma_beat, dma_done, mem_addr);
        end else begin
          exp_t e;
          logic [DW-1:0] rd;
          logic ok;
          e  = exp_q.pop_front();
          rd = dma_beat ? dma_rdata : core_rdata;
          ok = (dma_gnt == e.gnt) && (dma_beat == e.beat) && (dma_done == e.done) &&
               (core_stall == e.stall) && (mem_we == e.we) &&
               (!e.chk_addr || (mem_addr == e.addr)) && (!e.chk_rd || (rd == e.rdata));
          if (!ok) begin
            nfail++;
            $display("FAIL event#%0d: got gnt=%b beat=%b done=%b stall=%b addr=%h we=%h rdata=%h, required gnt=%b beat=%b done=%b stall=%b addr=%h we=%h rdata=%h",
                     nev, dma_gnt, dma_beat, dma_done, core_stall, mem_addr, mem_we, rd,
                     e.gnt, e.beat, e.done, e.stall, e.addr, e.we, e.rdata);
          end else begin
            $display("event#%0d ok: gnt=%b beat=%b done=%b stall=%b addr=%h we=%h rdata=%h",
                     nev, dma_gnt, dma_beat, dma_done, core_stall, mem_addr, mem_we, rd);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    nchk++;
    if ({dma_gnt, dma_beat, dma_done, core_stall, mem_we} !== 8'h00) begin
      nfail++;
      $display("FAIL %s: got gnt/beat/done/stall=%b we=%h, required 0000 we=0",
               name, {dma_gnt, dma_beat, dma_done, core_stall}, mem_we);
    end else begin
      $display("%s ok: outputs quiet", name);
    end
  endtask

  task automatic core_cyc(input logic [3:0] we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic chk, input logic [DW-1:0] rd);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    expect_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, addr, we, chk, rd);
    step();
    core_req = 1'b0;
  endtask

  task automatic dma_start(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    dma_req = 1'b1; dma_wr = wr; dma_addr = addr; dma_len = len;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b0, '0);
    step();
    dma_req = 1'b0;
  endtask

  logic [DW-1:0] wrap_d [4];
  logic [AW-1:0] wrap_a [4];

  initial begin
    wrap_d = '{32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4};
    wrap_a = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
    rst_n = 1'b0; core_req = 1'b0; core_we = 4'h0; core_addr = '0; core_wdata = '0;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    repeat (2) step();
    chk_quiet("reset_state");
    dma_req = 1'b0;
    #4 rst_n = 1'b1;
    step();

    // Core only: write then read-back in the next cycle.
    core_cyc(4'hF, 16'h0010, 32'hDEADBEEF, 1'b0, '0);
    core_cyc(4'h0, 16'h0010, '0, 1'b1, 32'hDEADBEEF);

    // Idle DMA write burst of 4 beats.
    dma_start(1'b1, 16'h0040, 5'd4);
    for (int i = 0; i < 4; i++) begin
      dma_wdata = 32'(i + 1);
      expect_ev(1'b0, 1'b1, i == 3, 1'b0, 1'b1, 16'(16'h0040 + 4*i), 4'hF, 1'b0, '0);
      step();
    end
    for (int i = 0; i < 4; i++) core_cyc(4'h0, 16'(16'h0040 + 4*i), '0, 1'b1, 32'(i + 1));

    // Starvation: core busy, DMA forced in after 8 blocked cycles.
    core_req = 1'b1; core_we = 4'h0; core_addr = 16'h0010;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 16'h0040; dma_len = 5'd2;
    for (int c = 0; c < 8; c++) begin
      expect_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b1, 32'hDEADBEEF);
      step();
    end
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b1, 32'hDEADBEEF);
    step();
    dma_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_ev(1'b0, 1'b1, i == 1, 1'b1, 1'b1, 16'(16'h0040 + 4*i), 4'h0, 1'b1, 32'(i + 1));
      step();
    end
    expect_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b1, 32'hDEADBEEF);
    step();
    core_req = 1'b0;

    // Address wrap at the top of the address space.
    for (int i = 0; i < 4; i++) core_cyc(4'hF, wrap_a[i], wrap_d[i], 1'b0, '0);
    dma_start(1'b0, 16'hFFF8, 5'd4);
    for (int i = 0; i < 4; i++) begin
      expect_ev(1'b0, 1'b1, i == 3, 1'b0, 1'b1, wrap_a[i], 4'h0, 1'b1, wrap_d[i]);
      step();
    end

    // len 0 performs exactly one beat.
    dma_start(1'b0, 16'h0040, 5'd0);
    expect_ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 4'h0, 1'b1, 32'd1);
    step();
    step();

    // len 31 clamps to 16 beats; the word just past the burst stays intact.
    core_cyc(4'hF, 16'h0140, 32'h5A5A5A5A, 1'b0, '0);
    dma_start(1'b1, 16'h0100, 5'd31);
    for (int i = 0; i < 16; i++) begin
      dma_wdata = 32'(32'h100 + i);
      expect_ev(1'b0, 1'b1, i == 15, 1'b0, 1'b1, 16'(16'h0100 + 4*i), 4'hF, 1'b0, '0);
      step();
    end
    step();
    core_cyc(4'h0, 16'h013C, '0, 1'b1, 32'h0000010F);
    core_cyc(4'h0, 16'h0140, '0, 1'b1, 32'h5A5A5A5A);

    // Reset during beat 2 of an 8-beat write burst.
    core_cyc(4'hF, 16'h0208, 32'h00000077, 1'b0, '0);
    dma_start(1'b1, 16'h0200, 5'd8);
    for (int i = 0; i < 2; i++) begin
      dma_wdata = 32'(32'hB0 + i);
      expect_ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'(16'h0200 + 4*i), 4'hF, 1'b0, '0);
      step();
    end
    dma_wdata = 32'hB2; core_req = 1'b1; core_we = 4'h0; core_addr = 16'h0200;
    #1 rst_n = 1'b0;
    #1 chk_quiet("reset_mid_burst");
    @(posedge clk);
    #2;
    expect_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 4'h0, 1'b1, 32'h000000B0);
    rst_n = 1'b1;
    step();
    core_req = 1'b0;
    core_cyc(4'h0, 16'h0204, '0, 1'b1, 32'h000000B1);
    core_cyc(4'h0, 16'h0208, '0, 1'b1, 32'h00000077);

    // dma_req held across done while the core is busy: no back-to-back grant.
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 16'h0040; dma_len = 5'd2;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'h0, 1'b0, '0);
    step();
    core_req = 1'b1; core_we = 4'h0; core_addr = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      expect_ev(1'b0, 1'b1, i == 1, 1'b1, 1'b1, 16'(16'h0040 + 4*i), 4'h0, 1'b1, 32'(i + 1));
      step();
    end
    for (int c = 0; c < 8; c++) begin
      expect_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b1, 32'hDEADBEEF);
      step();
    end
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 4'h0, 1'b1, 32'hDEADBEEF);
    step();
    dma_req = 1'b0; core_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_ev(1'b0, 1'b1, i == 1, 1'b0, 1'b1, 16'(16'h0040 + 4*i), 4'h0, 1'b1, 32'(i + 1));
      step();
    end
    repeat (2) step();

    nchk++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL queue_drain: got %0d unmatched expected events, required 0", exp_q.size());
    end else begin
      $display("queue_drain ok: all expected events observed");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
